// File: rtl/beam_steer_tx.sv
// Two-channel beam steering transmitter: one mono stream is fanned out to left/right
// speakers, with one channel delayed through a 64-entry circular sample buffer.
module beam_steer_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int CENTER     = 30,
    parameter int MAX_INDEX  = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  ready,
    input  logic [5:0]            delay_index,
    input  logic                  index_load,
    output logic [DATA_WIDTH-1:0] left_data_out,
    output logic [DATA_WIDTH-1:0] right_data_out,
    output logic                  out_valid,
    output logic [5:0]            active_index,
    output logic                  idx_err
);

    localparam logic [5:0] CENTER_IDX = 6'(CENTER);
    localparam logic [5:0] MAX_IDX    = 6'(MAX_INDEX);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state;
    state_t                next_state;
    logic [5:0]            clear_cnt;
    logic [5:0]            wp;
    logic [DATA_WIDTH-1:0] sample_buf [64];

    logic                  index_ok;
    logic                  accept;
    logic [5:0]            eff_index;
    logic [5:0]            left_delay;
    logic [5:0]            right_delay;
    logic [5:0]            left_addr;
    logic [5:0]            right_addr;
    logic [DATA_WIDTH-1:0] left_tap;
    logic [DATA_WIDTH-1:0] right_tap;

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            CLEAR:   if (clear_cnt == 6'd63) next_state = RUN;
            RUN:     ready = 1'b1;
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= CLEAR;
            clear_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) clear_cnt <= clear_cnt + 6'd1;
        end
    end

    // A legal index loaded this cycle already steers the sample accepted this cycle.
    assign index_ok  = index_load && (delay_index <= MAX_IDX);
    assign eff_index = index_ok ? delay_index : active_index;
    assign accept    = sample_valid && ready;

    always_comb begin
        left_delay  = '0;
        right_delay = '0;
        if (eff_index >= CENTER_IDX) right_delay = eff_index - CENTER_IDX;
        else                         left_delay  = CENTER_IDX - eff_index;
    end

    // Pointer arithmetic wraps naturally in 6 bits, giving the modulo-64 tap address.
    assign left_addr  = wp - left_delay;
    assign right_addr = wp - right_delay;
    assign left_tap   = (left_delay == 6'd0)  ? sample_in : sample_buf[left_addr];
    assign right_tap  = (right_delay == 6'd0) ? sample_in : sample_buf[right_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == CLEAR) sample_buf[clear_cnt] <= '0;
            else if (accept)    sample_buf[wp]        <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wp             <= '0;
            active_index   <= CENTER_IDX;
            left_data_out  <= '0;
            right_data_out <= '0;
            out_valid      <= 1'b0;
            idx_err        <= 1'b0;
        end else begin
            idx_err   <= index_load && (delay_index > MAX_IDX);
            out_valid <= accept;
            if (index_ok) active_index <= delay_index;
            if (accept) begin
                wp             <= wp + 6'd1;
                left_data_out  <= left_tap;
                right_data_out <= right_tap;
            end
        end
    end

endmodule

// File: tb/tb_beam_steer_tx.sv
// Self-checking bench for beam_steer_tx: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a sample-history model.
module tb_beam_steer_tx;

    logic        clk;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        ready;
    logic [5:0]  delay_index;
    logic        index_load;
    logic [15:0] left_data_out;
    logic [15:0] right_data_out;
    logic        out_valid;
    logic [5:0]  active_index;
    logic        idx_err;

    int tests_run = 0;
    int tests_failed = 0;

    beam_steer_tx dut (
        .clk           (clk),
        .reset         (reset),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .ready         (ready),
        .delay_index   (delay_index),
        .index_load    (index_load),
        .left_data_out (left_data_out),
        .right_data_out(right_data_out),
        .out_valid     (out_valid),
        .active_index  (active_index),
        .idx_err       (idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the history of accepted samples, pre-filled with 64 zeros after clear.
    logic [15:0] hist[$];
    int          clear_left;
    bit          model_init = 1'b0;
    logic        exp_valid;
    logic        exp_err;
    logic [5:0]  exp_active;
    logic [15:0] exp_left;
    logic [15:0] exp_right;

    always @(posedge clk) begin
        if (!reset) begin
            hist.delete();
            for (int i = 0; i < 64; i++) hist.push_back(16'd0);
            clear_left = 64;
            exp_active = 6'd30;
            exp_left   = 16'd0;
            exp_right  = 16'd0;
            exp_valid  = 1'b0;
            exp_err    = 1'b0;
            model_init = 1'b1;
        end else if (model_init) begin
            int eff;
            int offset;
            bit ok;
            ok  = index_load && (delay_index <= 6'd60);
            eff = ok ? int'(delay_index) : int'(exp_active);
            if (clear_left == 0 && sample_valid) begin
                hist.push_back(sample_in);
                if (hist.size() > 64) void'(hist.pop_front());
                offset    = eff - 30;
                exp_right = (offset > 0)  ? hist[hist.size() - 1 - offset] : sample_in;
                exp_left  = (offset < 0)  ? hist[hist.size() - 1 + offset] : sample_in;
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            if (ok) exp_active = delay_index;
            exp_err = index_load && (delay_index > 6'd60);
            if (clear_left > 0) clear_left--;
        end
    end

    always @(negedge clk) begin
        if (model_init) begin
            checkOutput("ready",        ready,          clear_left == 0);
            checkOutput("out_valid",    out_valid,      exp_valid);
            checkOutput("idx_err",      idx_err,        exp_err);
            checkOutput("active_index", active_index,   exp_active);
            checkOutput("left_data",    left_data_out,  exp_left);
            checkOutput("right_data",   right_data_out, exp_right);
        end
    end

    task automatic applyStimulus(input logic v, input logic [15:0] s, input logic ld, input logic [5:0] idx);
        sample_valid = v;
        sample_in    = s;
        index_load   = ld;
        delay_index  = idx;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        index_load   = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus(1'b0, 16'd0, 1'b0, 6'd0);
        applyStimulus(1'b0, 16'd0, 1'b0, 6'd0);
        reset = 1'b1;
    endtask

    // Counts not-ready cycles until RUN; an optional index load rides on the first CLEAR cycle.
    task automatic waitReady(input logic v, input logic ld, input logic [5:0] idx, output int n);
        n = 0;
        while (!ready && n < 200) begin
            applyStimulus(v, 16'h0007, ld && (n == 0), idx);
            n++;
        end
        checkOutput("clear_length", n, 64);
    endtask

    initial begin
        int n;
        reset        = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        index_load   = 1'b0;
        delay_index  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_active_index", active_index, 30);
        checkOutput("reset_ready", ready, 0);
        reset = 1'b1;

        // Constant valid during clear: 64 not-ready cycles, then broadside ramp.
        waitReady(1'b1, 1'b0, 6'd0, n);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, 16'(k), 1'b0, 6'd0);
            checkOutput("bs_valid", out_valid, 1);
            checkOutput("bs_left",  left_data_out,  k);
            checkOutput("bs_right", right_data_out, k);
        end

        // Index 35 loaded with the first sample: right lags by five.
        doReset();
        waitReady(1'b0, 1'b0, 6'd0, n);
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b1, 16'(k), k == 1, 6'd35);
            checkOutput("i35_left",  left_data_out,  k);
            checkOutput("i35_right", right_data_out, (k > 5) ? k - 5 : 0);
        end

        // Index 0 loaded during clear: left lags by thirty.
        doReset();
        waitReady(1'b0, 1'b1, 6'd0, n);
        checkOutput("i0_active", active_index, 0);
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b1, 16'(k), 1'b0, 6'd0);
            checkOutput("i0_right", right_data_out, k);
            checkOutput("i0_left",  left_data_out,  (k > 30) ? k - 30 : 0);
        end

        // Illegal index 61 with 40 active.
        applyStimulus(1'b1, 16'd100, 1'b1, 6'd40);
        applyStimulus(1'b1, 16'd101, 1'b1, 6'd61);
        checkOutput("bad_idx_err",    idx_err, 1);
        checkOutput("bad_idx_active", active_index, 40);
        checkOutput("bad_idx_valid",  out_valid, 1);
        applyStimulus(1'b1, 16'd102, 1'b0, 6'd0);
        checkOutput("bad_idx_pulse_end", idx_err, 0);

        // Index 60 stream interrupted by reset at sample 50.
        doReset();
        waitReady(1'b0, 1'b0, 6'd0, n);
        for (int k = 1; k < 50; k++) begin
            applyStimulus(1'b1, 16'(k), k == 1, 6'd60);
            checkOutput("i60_left",  left_data_out,  k);
            checkOutput("i60_right", right_data_out, (k > 30) ? k - 30 : 0);
        end
        reset = 1'b0;
        applyStimulus(1'b1, 16'd50, 1'b0, 6'd0);
        checkOutput("midrun_valid", out_valid, 0);
        checkOutput("midrun_left",  left_data_out, 0);
        checkOutput("midrun_right", right_data_out, 0);
        reset = 1'b1;
        waitReady(1'b1, 1'b0, 6'd0, n);
        checkOutput("midrun_active", active_index, 30);

        // Randomized traffic with occasional index loads and rare resets.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            applyStimulus(1'(($urandom_range(0, 3)) != 0), 16'($urandom),
                          1'($urandom_range(0, 15) == 0), 6'($urandom_range(0, 63)));
        end
        reset = 1'b1;
        applyStimulus(1'b0, 16'd0, 1'b0, 6'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
